// File: rtl/alib_fifo_pkg.sv
// rtl/alib_fifo_pkg.sv - shared pointer/occupancy width helpers for the alib FIFOs
package alib_fifo_pkg;

    // Bits needed to index 'entries' locations (at least one bit).
    function automatic int ptr_width(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

    // Bits needed to hold an occupancy count of 0..entries inclusive.
    function automatic int occ_width(input int entries);
        return $clog2(entries) + 1;
    endfunction

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/alib_bit_extract.sv
// rtl/alib_bit_extract.sv - combinational bit-window select and right-align from word storage
module alib_bit_extract
    import alib_fifo_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int WIDTH_INPUT  = 8,
    parameter int WIDTH_OUTPUT = 16,
    parameter int RPW          = ptr_width(DEPTH * WIDTH_INPUT),
    parameter int LENW         = $clog2(WIDTH_OUTPUT) + 1
) (
    input  logic [DEPTH-1:0][WIDTH_INPUT-1:0] words,
    input  logic [RPW-1:0]                    rd_ptr,
    input  logic [LENW-1:0]                   len,
    output logic [WIDTH_OUTPUT-1:0]           data
);

    localparam int WPW  = ptr_width(DEPTH);
    localparam int OFW  = ptr_width(WIDTH_INPUT);
    // A read starting mid-word can touch one extra word beyond the aligned span.
    localparam int NW   = ceil_div(WIDTH_OUTPUT, WIDTH_INPUT) + 1;
    localparam int WINW = NW * WIDTH_INPUT;

    logic [WPW-1:0]          base_word;
    logic [OFW-1:0]          offset;
    logic [WPW:0]            idx_sum;
    logic [WINW-1:0]         window;
    logic [WIDTH_OUTPUT-1:0] top;
    logic [LENW-1:0]         shamt;

    assign base_word = WPW'(32'(rd_ptr) / WIDTH_INPUT);
    assign offset    = OFW'(32'(rd_ptr) % WIDTH_INPUT);

    // Gather NW consecutive words (wrapping at DEPTH) oldest-first, then align the read bit to the MSB.
    always_comb begin
        idx_sum = '0;
        window  = '0;
        for (int k = 0; k < NW; k++) begin
            idx_sum = {1'b0, base_word} + (WPW+1)'(k);
            if (32'(idx_sum) >= DEPTH) begin
                idx_sum = idx_sum - (WPW+1)'(DEPTH);
            end
            window[WINW-1-k*WIDTH_INPUT -: WIDTH_INPUT] = words[idx_sum[WPW-1:0]];
        end
        top   = WIDTH_OUTPUT'((window << offset) >> (WINW - WIDTH_OUTPUT));
        shamt = LENW'(WIDTH_OUTPUT) - len;
        if (len == '0 || 32'(len) > WIDTH_OUTPUT) begin
            data = '0;
        end else begin
            data = top >> shamt;
        end
    end

endmodule

// File: rtl/alib_unpacker_fifo.sv
// rtl/alib_unpacker_fifo.sv - word-in, variable-bit-length-out bitstream FIFO
module alib_unpacker_fifo
    import alib_fifo_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int WIDTH_INPUT  = 8,
    parameter int WIDTH_OUTPUT = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [WIDTH_INPUT-1:0]                i_wr_data,
    input  logic                                  i_wr_en,
    output logic                                  o_full,
    input  logic                                  i_rd_en,
    input  logic [$clog2(WIDTH_OUTPUT):0]         i_rd_data_len,
    output logic [WIDTH_OUTPUT-1:0]               o_rd_data,
    output logic                                  o_rd_valid,
    output logic                                  o_empty,
    output logic [$clog2(DEPTH*WIDTH_INPUT):0]    o_bits_left,
    output logic                                  o_underflow
);

    localparam int TOTAL_BITS = DEPTH * WIDTH_INPUT;
    localparam int WPW        = ptr_width(DEPTH);
    localparam int RPW        = ptr_width(TOTAL_BITS);
    localparam int OCCW       = occ_width(TOTAL_BITS);
    localparam int LENW       = $clog2(WIDTH_OUTPUT) + 1;

    logic [DEPTH-1:0][WIDTH_INPUT-1:0] mem;
    logic [WPW-1:0]                    wr_ptr;
    logic [WPW-1:0]                    wr_ptr_next;
    logic [RPW-1:0]                    rd_ptr;
    logic [RPW-1:0]                    rd_ptr_next;
    logic [RPW:0]                      rd_sum;
    logic [OCCW-1:0]                   count;
    logic [OCCW-1:0]                   count_next;
    logic                              wr_accept;
    logic                              rd_accept;
    logic [WIDTH_OUTPUT-1:0]           extract_data;

    // Status comes straight from the registered bit count.
    assign o_full      = 32'(count) > (TOTAL_BITS - WIDTH_INPUT);
    assign o_empty     = (count == '0);
    assign o_bits_left = count;

    assign wr_accept = i_wr_en && !o_full;
    assign rd_accept = i_rd_en
                    && (32'(i_rd_data_len) <= WIDTH_OUTPUT)
                    && (32'(i_rd_data_len) <= 32'(count));

    alib_bit_extract #(
        .DEPTH        (DEPTH),
        .WIDTH_INPUT  (WIDTH_INPUT),
        .WIDTH_OUTPUT (WIDTH_OUTPUT),
        .RPW          (RPW),
        .LENW         (LENW)
    ) u_bit_extract (
        .words  (mem),
        .rd_ptr (rd_ptr),
        .len    (i_rd_data_len),
        .data   (extract_data)
    );

    // Next pointer and occupancy values; read length is taken from the pre-edge count only.
    always_comb begin
        wr_ptr_next = (wr_ptr == WPW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        rd_sum      = {1'b0, rd_ptr} + (RPW+1)'(i_rd_data_len);
        if (32'(rd_sum) >= TOTAL_BITS) begin
            rd_sum = rd_sum - (RPW+1)'(TOTAL_BITS);
        end
        rd_ptr_next = rd_sum[RPW-1:0];
        count_next  = count
                    + (wr_accept ? OCCW'(WIDTH_INPUT) : '0)
                    - (rd_accept ? OCCW'(i_rd_data_len) : '0);
    end

    // Word storage; contents are not reset since occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    // Pointers, occupancy and registered read results.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_rd_data   <= '0;
            o_rd_valid  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr_next;
            end
            if (rd_accept) begin
                rd_ptr    <= rd_ptr_next;
                o_rd_data <= extract_data;
            end
            count       <= count_next;
            o_rd_valid  <= rd_accept;
            o_underflow <= i_rd_en && !rd_accept;
        end
    end

endmodule

// File: tb/tb_alib_unpacker_fifo.sv
// tb/tb_alib_unpacker_fifo.sv - self-checking bench for alib_unpacker_fifo
module tb_alib_unpacker_fifo;

    localparam int DEPTH = 16;
    localparam int WI    = 8;
    localparam int WO    = 16;
    localparam int LW    = 5;
    localparam int BLW   = 8;
    localparam int TOTAL = DEPTH * WI;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WI-1:0] wr_data;
    logic          wr_en;
    logic          full;
    logic          rd_en;
    logic [LW-1:0] rd_len;
    logic [WO-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic [BLW-1:0] bits_left;
    logic          underflow;

    int vec_count  = 0;
    int miscompares = 0;

    typedef struct {
        logic          wr;
        logic [7:0]    wd;
        logic          rd;
        logic [4:0]    len;
        logic          ev;
        logic [15:0]   ed;
        logic          eu;
        int            ebl;
        logic          ef;
        logic          ee;
    } vec_t;

    vec_t tbl[$];
    bit   mq[$];

    alib_unpacker_fifo #(
        .DEPTH        (DEPTH),
        .WIDTH_INPUT  (WI),
        .WIDTH_OUTPUT (WO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_wr_data     (wr_data),
        .i_wr_en       (wr_en),
        .o_full        (full),
        .i_rd_en       (rd_en),
        .i_rd_data_len (rd_len),
        .o_rd_data     (rd_data),
        .o_rd_valid    (rd_valid),
        .o_empty       (empty),
        .o_bits_left   (bits_left),
        .o_underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_out(input string name, input logic ev, input logic [15:0] ed,
                             input logic eu, input int ebl, input logic ef, input logic ee);
        vec_count++;
        if (rd_valid !== ev || rd_data !== ed || underflow !== eu ||
            bits_left !== BLW'(ebl) || full !== ef || empty !== ee) begin
            miscompares++;
            $display("FAIL %s: got valid=%0b data=%h uf=%0b bits=%0d full=%0b empty=%0b; expected valid=%0b data=%h uf=%0b bits=%0d full=%0b empty=%0b",
                     name, rd_valid, rd_data, underflow, bits_left, full, empty,
                     ev, ed, eu, ebl, ef, ee);
        end
    endtask

    task automatic drive(input logic w, input logic [7:0] wd, input logic r, input logic [4:0] l);
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        rd_len  = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  words[16];
    logic [15:0] last_data;

    initial begin
        rst_n = 1'b0;
        drive(0, 8'h00, 0, 5'd0);
        tick();
        tick();
        check_out("reset_hold", 0, 16'h0000, 0, 0, 0, 1);
        #2 rst_n = 1'b1;

        // Directed table: basic extraction, len 0, underflow, simultaneous write+read, len > WO.
        tbl.push_back('{1'b1, 8'hA5, 1'b0, 5'd0,  1'b0, 16'h0000, 1'b0, 8,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h3C, 1'b0, 5'd0,  1'b0, 16'h0000, 1'b0, 16, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 5'd4,  1'b1, 16'h000A, 1'b0, 12, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 5'd8,  1'b1, 16'h0053, 1'b0, 4,  1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 5'd4,  1'b1, 16'h000C, 1'b0, 0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 5'd0,  1'b0, 16'h000C, 1'b0, 0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 5'd0,  1'b1, 16'h0000, 1'b0, 0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 5'd1,  1'b0, 16'h0000, 1'b1, 0,  1'b0, 1'b1});
        tbl.push_back('{1'b1, 8'h12, 1'b0, 5'd0,  1'b0, 16'h0000, 1'b0, 8,  1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 5'd12, 1'b0, 16'h0000, 1'b1, 8,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'hFF, 1'b1, 5'd8,  1'b1, 16'h0012, 1'b0, 8,  1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 5'd8,  1'b1, 16'h00FF, 1'b0, 0,  1'b0, 1'b1});
        tbl.push_back('{1'b1, 8'h12, 1'b0, 5'd0,  1'b0, 16'h00FF, 1'b0, 8,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h34, 1'b0, 5'd0,  1'b0, 16'h00FF, 1'b0, 16, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 5'd17, 1'b0, 16'h00FF, 1'b1, 16, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 16'h1234, 1'b0, 0,  1'b0, 1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].len);
            tick();
            check_out($sformatf("table_%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eu,
                      tbl[i].ebl, tbl[i].ef, tbl[i].ee);
        end

        // Fill to full (storage already rotated), reject a 17th write, then drain word by word.
        for (int i = 0; i < 16; i++) begin
            words[i] = 8'((i * 37 + 5) & 8'hFF);
            drive(1, words[i], 0, 5'd0);
            tick();
            check_out($sformatf("fill_%0d", i), 0, 16'h1234, 0, (i + 1) * 8, (i == 15), 0);
        end
        drive(1, 8'hEE, 0, 5'd0);
        tick();
        check_out("write_when_full", 0, 16'h1234, 0, 128, 1, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 8'h00, 1, 5'd8);
            tick();
            check_out($sformatf("drain_%0d", i), 1, {8'h00, words[i]}, 0, 120 - i * 8, 0, (i == 15));
        end

        // Asynchronous reset asserted and released between edges.
        drive(1, 8'h5A, 0, 5'd0);
        tick();
        check_out("pre_reset_write", 0, {8'h00, words[15]}, 0, 8, 0, 0);
        drive(0, 8'h00, 0, 5'd0);
        #3 rst_n = 1'b0;
        #1;
        check_out("async_reset", 0, 16'h0000, 0, 0, 0, 1);
        #2 rst_n = 1'b1;
        tick();
        check_out("post_reset_idle", 0, 16'h0000, 0, 0, 0, 1);

        // Randomized stream against a bit-queue model.
        begin
            int   written = 0;
            int   cyc = 0;
            logic w, r, wacc, racc, eu, ev;
            logic [7:0] wd;
            logic [4:0] l;
            logic [15:0] ed;
            mq.delete();
            last_data = 16'h0000;
            while ((written < 40 || mq.size() > 0) && cyc < 3000) begin
                cyc++;
                w  = (written < 40) && ($urandom_range(0, 99) < 60);
                wd = 8'($urandom);
                r  = ($urandom_range(0, 99) < 55);
                if (written >= 40 && mq.size() > 0 && $urandom_range(0, 3) != 0)
                    l = 5'($urandom_range(1, (mq.size() < 16) ? mq.size() : 16));
                else
                    l = 5'($urandom_range(1, 16));
                wacc = w && (mq.size() <= TOTAL - WI);
                racc = r && (int'(l) <= mq.size());
                eu   = r && !racc;
                ev   = racc;
                ed   = last_data;
                if (racc) begin
                    ed = 16'h0000;
                    for (int j = 0; j < int'(l); j++) begin
                        ed = {ed[14:0], mq.pop_front()};
                    end
                    last_data = ed;
                end
                if (wacc) begin
                    for (int j = WI - 1; j >= 0; j--) mq.push_back(wd[j]);
                    written++;
                end
                drive(w, wd, r, l);
                tick();
                check_out($sformatf("rand_%0d", cyc), ev, ed, eu, mq.size(),
                          (mq.size() > TOTAL - WI), (mq.size() == 0));
            end
            if (cyc >= 3000) begin
                vec_count++;
                miscompares++;
                $display("FAIL rand_budget: got %0d words written and %0d bits left, expected 40 and 0", written, mq.size());
            end
        end

        drive(0, 8'h00, 0, 5'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
